multi_cycle_control_unit: RTL
=============================

Name: multi_cycle_control_unit

Overview:
Control FSM for the multi-cycle CPU; successor to the single-cycle combinational decoder. It sequences each instruction through IF/ID/EXE/MEM/WB states and stalls on a memory-ready handshake. Datapath select and strobe signals are decoded from the current state plus an opcode latched in ID. Sits between the IR/flag outputs of the datapath and all datapath muxes and write enables.

Parameters:
OP_W, 6, opcode width; opcode constants in the package are defined at this width.
ILLEGAL_TRAP, 1, 1: an undefined opcode enters HALT; 0: it retires as a NOP.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-low reset
Opcode  in  OP_W  IR opcode field; valid from the cycle after IRWre
zero  in  1  ALU result == 0
sign  in  1  ALU result MSB
mem_ready  in  1  instruction/data memory access complete this cycle
PCWre  out  1  PC write enable
IRWre  out  1  IR write enable
InsMemRW  out  1  1 = instruction memory read
mRD  out  1  data memory read
mWR  out  1  data memory write
RegWre  out  1  register file write enable
RegDst  out  2  00 = $31, 01 = rt, 10 = rd
WrRegDSrc  out  1  0 = PC+4, 1 = DB bus
DBDataSrc  out  1  0 = ALU result, 1 = data memory
ALUsrcA  out  1  0 = rs, 1 = sa
ALUsrcB  out  1  0 = rt, 1 = extended immediate
ExtSel  out  1  0 = zero-extend, 1 = sign-extend
PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = rs (jr), 11 = jump target
ALUOp  out  3  000 add, 001 sub, 010 B<<A, 011 or, 100 and, 101 signed slt, 110 xor
state_o  out  4  current state, for debug
retire  out  1  one-cycle pulse when an instruction completes

Behaviour:
- States (4-bit): IF=0, ID=1, EXE_AL=2, EXE_BR=3, EXE_LS=4, MEM=5, WB_AL=6, WB_LD=7, HALT=8.
- Reset (RST=0, asynchronous): state=IF, op_q=0. While RST=0, all outputs are 0 except InsMemRW=1 and state_o=0.
- IF: InsMemRW=1, IRWre=mem_ready. Stay in IF until mem_ready=1, then go to ID.
- ID: latch op_q<=Opcode.
  - j: PCSrc=11.
  - jr: PCSrc=10.
  - jal: PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0.
  - j, jr and jal all assert PCWre=1 and retire=1, then go to IF.
  - halt: go to HALT.
  - R-type and immediate ALU ops: go to EXE_AL.
  - beq/bne/bltz: go to EXE_BR.
  - lw/sw: go to EXE_LS.
  - Undefined opcode: HALT if ILLEGAL_TRAP=1, else PCWre=1, PCSrc=00, retire=1, go to IF.
- EXE_AL: selects per op_q; always go to WB_AL.
- WB_AL: selects held; RegWre=1, WrRegDSrc=1, DBDataSrc=0, PCWre=1, PCSrc=00, retire=1; go to IF.
- EXE_BR: ALUOp=001, ALUsrcB=0.
  - Taken: beq when zero=1, bne when zero=0, bltz when sign=1.
  - Taken gives PCSrc=01, otherwise 00.
  - PCWre=1, retire=1; go to IF.
- EXE_LS: ALUOp=000, ALUsrcB=1, ExtSel=1; go to MEM.
- MEM: address selects held; mRD=1 for lw, mWR=1 for sw. Stay in MEM until mem_ready=1.
  - sw with mem_ready=1: PCWre=1, retire=1, go to IF.
  - lw with mem_ready=1: go to WB_LD.
- WB_LD: RegWre=1, RegDst=01, WrRegDSrc=1, DBDataSrc=1, PCWre=1, retire=1; go to IF.
- HALT: all strobes 0. Leaves only via reset.
- Selects for add/sub/and/or/xor/slt/sll: ALUsrcB=0, RegDst=10. sll uses ALUsrcA=1.
- Selects for addiu/slti: ALUsrcB=1, ExtSel=1, RegDst=01.
- Selects for andi/ori/xori: ALUsrcB=1, ExtSel=0, RegDst=01.
- Outside the states listed above, every strobe is 0.
- Latency in cycles, excluding waits: j/jr/jal 2; branch 3; ALU 4; sw 4; lw 5. Each cycle with mem_ready=0 adds 1.
- Reset mid-instruction: abort immediately to IF; no write strobe asserts after RST falls.

Decomposition:
- Package cu_pkg holds:
  - opcode constants: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, xori 010011, sll 011000, slt 100110, slti 100111, sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110, j 111000, jr 111001, jal 111010, halt 111111;
  - state encodings;
  - ALUOp, PCSrc and RegDst codes.
- Sub-module cu_op_decode: combinational op_q-to-selects decoder (ALUOp, ALUsrcA/B, ExtSel, RegDst, op class). The FSM is the top.

Test Plan:
- Release RST with mem_ready=1 and Opcode=add -> states 0,1,2,6,0; RegWre=1 and PCWre=1 only in WB_AL; ALUOp=000; RegDst=10.
- lw with mem_ready low for 2 cycles in MEM -> mRD=1 for 3 cycles; WB_LD has DBDataSrc=1 and RegDst=01; retire after 7 cycles.
- beq with zero=1 -> PCSrc=01. bne with zero=1 -> PCSrc=00. bltz with sign=1 -> PCSrc=01. PCWre=1 once in each case.
- jal -> in ID: PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0, retire=1; next state is IF.
- Opcode=101010 -> HALT with ILLEGAL_TRAP=1; NOP retire with ILLEGAL_TRAP=0. halt -> state_o=8 held for 20 cycles with all strobes 0.
- RST asserted during MEM of sw -> mWR drops asynchronously, state_o=0; after release, IF resumes.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states,
// datapath select codes and the opcode classifier used by the FSM and decoder.
package cu_pkg;

    localparam int OP_WIDTH = 6;

    localparam logic [OP_WIDTH-1:0] OP_ADD   = 6'b000000;
    localparam logic [OP_WIDTH-1:0] OP_SUB   = 6'b000001;
    localparam logic [OP_WIDTH-1:0] OP_ADDIU = 6'b000010;
    localparam logic [OP_WIDTH-1:0] OP_AND   = 6'b010000;
    localparam logic [OP_WIDTH-1:0] OP_ANDI  = 6'b010001;
    localparam logic [OP_WIDTH-1:0] OP_ORI   = 6'b010010;
    localparam logic [OP_WIDTH-1:0] OP_XORI  = 6'b010011;
    localparam logic [OP_WIDTH-1:0] OP_SLL   = 6'b011000;
    localparam logic [OP_WIDTH-1:0] OP_SLT   = 6'b100110;
    localparam logic [OP_WIDTH-1:0] OP_SLTI  = 6'b100111;
    localparam logic [OP_WIDTH-1:0] OP_SW    = 6'b110000;
    localparam logic [OP_WIDTH-1:0] OP_LW    = 6'b110001;
    localparam logic [OP_WIDTH-1:0] OP_BEQ   = 6'b110100;
    localparam logic [OP_WIDTH-1:0] OP_BNE   = 6'b110101;
    localparam logic [OP_WIDTH-1:0] OP_BLTZ  = 6'b110110;
    localparam logic [OP_WIDTH-1:0] OP_J     = 6'b111000;
    localparam logic [OP_WIDTH-1:0] OP_JR    = 6'b111001;
    localparam logic [OP_WIDTH-1:0] OP_JAL   = 6'b111010;
    localparam logic [OP_WIDTH-1:0] OP_HALT  = 6'b111111;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_AL = 4'd2,
        S_EXE_BR = 4'd3,
        S_EXE_LS = 4'd4,
        S_MEM    = 4'd5,
        S_WB_AL  = 4'd6,
        S_WB_LD  = 4'd7,
        S_HALT   = 4'd8
    } cuState;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [1:0] DST_R31 = 2'b00;
    localparam logic [1:0] DST_RT  = 2'b01;
    localparam logic [1:0] DST_RD  = 2'b10;

    typedef enum logic [3:0] {
        CLS_ALU,
        CLS_BR,
        CLS_LW,
        CLS_SW,
        CLS_J,
        CLS_JR,
        CLS_JAL,
        CLS_HALT,
        CLS_ILLEGAL
    } opClass;

    function automatic opClass classifyOp(input logic [OP_WIDTH-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_XORI,
            OP_SLL, OP_SLT, OP_SLTI:        return CLS_ALU;
            OP_BEQ, OP_BNE, OP_BLTZ:        return CLS_BR;
            OP_LW:                          return CLS_LW;
            OP_SW:                          return CLS_SW;
            OP_J:                           return CLS_J;
            OP_JR:                          return CLS_JR;
            OP_JAL:                         return CLS_JAL;
            OP_HALT:                        return CLS_HALT;
            default:                        return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/cu_op_decode.sv
// Combinational decoder from the latched opcode to ALU/operand/destination
// selects and the opcode class consumed by the control FSM.
module cu_op_decode
    import cu_pkg::*;
(
    input  logic [OP_WIDTH-1:0] op,
    output logic [2:0]          aluOp,
    output logic                aluSrcA,
    output logic                aluSrcB,
    output logic                extSel,
    output logic [1:0]          regDst,
    output opClass              opCls
);

    assign opCls = classifyOp(op);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        aluOp   = ALU_ADD;
        aluSrcA = 1'b0;
        aluSrcB = 1'b0;
        extSel  = 1'b0;
        regDst  = DST_R31;
        case (op)
            OP_ADD:   regDst = DST_RD;
            OP_SUB:   begin aluOp = ALU_SUB; regDst = DST_RD; end
            OP_AND:   begin aluOp = ALU_AND; regDst = DST_RD; end
            OP_SLT:   begin aluOp = ALU_SLT; regDst = DST_RD; end
            OP_SLL:   begin aluOp = ALU_SLL; aluSrcA = 1'b1; regDst = DST_RD; end
            OP_ADDIU: begin aluSrcB = 1'b1; extSel = 1'b1; regDst = DST_RT; end
            OP_SLTI:  begin aluOp = ALU_SLT; aluSrcB = 1'b1; extSel = 1'b1; regDst = DST_RT; end
            OP_ANDI:  begin aluOp = ALU_AND; aluSrcB = 1'b1; regDst = DST_RT; end
            OP_ORI:   begin aluOp = ALU_OR;  aluSrcB = 1'b1; regDst = DST_RT; end
            OP_XORI:  begin aluOp = ALU_XOR; aluSrcB = 1'b1; regDst = DST_RT; end
            OP_LW, OP_SW: begin aluSrcB = 1'b1; extSel = 1'b1; regDst = DST_RT; end
            OP_BEQ, OP_BNE, OP_BLTZ: aluOp = ALU_SUB;
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle CPU control FSM: sequences IF/ID/EXE/MEM/WB, stalls on mem_ready,
// and drives datapath selects from the current state and the opcode latched in ID.
module multi_cycle_control_unit
    import cu_pkg::*;
#(
    parameter int OP_W         = OP_WIDTH,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [OP_W-1:0] Opcode,
    input  logic            zero,
    input  logic            sign,
    input  logic            mem_ready,
    output logic            PCWre,
    output logic            IRWre,
    output logic            InsMemRW,
    output logic            mRD,
    output logic            mWR,
    output logic            RegWre,
    output logic [1:0]      RegDst,
    output logic            WrRegDSrc,
    output logic            DBDataSrc,
    output logic            ALUsrcA,
    output logic            ALUsrcB,
    output logic            ExtSel,
    output logic [1:0]      PCSrc,
    output logic [2:0]      ALUOp,
    output logic [3:0]      state_o,
    output logic            retire
);

    cuState          state, nextState;
    logic [OP_W-1:0] opQ;
    opClass          idCls, exCls;
    logic [2:0]      decAluOp;
    logic            decSrcA, decSrcB, decExt;
    logic [1:0]      decRegDst;
    logic            branchTaken;

    cu_op_decode uDecode (
        .op      (opQ),
        .aluOp   (decAluOp),
        .aluSrcA (decSrcA),
        .aluSrcB (decSrcB),
        .extSel  (decExt),
        .regDst  (decRegDst),
        .opCls   (exCls)
    );

    // ID decodes the live IR field; later states use the latched copy.
    assign idCls   = classifyOp(Opcode);
    assign state_o = state;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IF;
            opQ   <= '0;
        end else begin
            state <= nextState;
            if (state == S_ID) opQ <= Opcode;
        end
    end

    always_comb begin
        branchTaken = 1'b0;
        case (opQ)
            OP_BEQ:  branchTaken = zero;
            OP_BNE:  branchTaken = !zero;
            OP_BLTZ: branchTaken = sign;
            default: branchTaken = 1'b0;
        endcase
    end

    always_comb begin
        nextState = state;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        RegWre    = 1'b0;
        RegDst    = DST_R31;
        WrRegDSrc = 1'b0;
        DBDataSrc = 1'b0;
        ALUsrcA   = 1'b0;
        ALUsrcB   = 1'b0;
        ExtSel    = 1'b0;
        PCSrc     = PC_NEXT;
        ALUOp     = ALU_ADD;
        retire    = 1'b0;
        case (state)
            S_IF: begin
                InsMemRW = 1'b1;
                // Reset forces IF asynchronously; keep the IR write quiet while held.
                IRWre    = mem_ready && RST;
                if (mem_ready) nextState = S_ID;
            end
            S_ID: begin
                case (idCls)
                    CLS_J, CLS_JR, CLS_JAL: begin
                        PCWre     = 1'b1;
                        retire    = 1'b1;
                        PCSrc     = (idCls == CLS_JR) ? PC_RS : PC_JUMP;
                        RegWre    = (idCls == CLS_JAL);
                        nextState = S_IF;
                    end
                    CLS_ALU:  nextState = S_EXE_AL;
                    CLS_BR:   nextState = S_EXE_BR;
                    CLS_LW,
                    CLS_SW:   nextState = S_EXE_LS;
                    CLS_HALT: nextState = S_HALT;
                    default: begin
                        if (ILLEGAL_TRAP) begin
                            nextState = S_HALT;
                        end else begin
                            PCWre     = 1'b1;
                            retire    = 1'b1;
                            nextState = S_IF;
                        end
                    end
                endcase
            end
            S_EXE_AL, S_WB_AL: begin
                ALUOp   = decAluOp;
                ALUsrcA = decSrcA;
                ALUsrcB = decSrcB;
                ExtSel  = decExt;
                RegDst  = decRegDst;
                if (state == S_WB_AL) begin
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                    PCWre     = 1'b1;
                    retire    = 1'b1;
                    nextState = S_IF;
                end else begin
                    nextState = S_WB_AL;
                end
            end
            S_EXE_BR: begin
                ALUOp     = ALU_SUB;
                PCSrc     = branchTaken ? PC_BRANCH : PC_NEXT;
                PCWre     = 1'b1;
                retire    = 1'b1;
                nextState = S_IF;
            end
            S_EXE_LS, S_MEM: begin
                ALUOp   = ALU_ADD;
                ALUsrcB = 1'b1;
                ExtSel  = 1'b1;
                if (state == S_EXE_LS) begin
                    nextState = S_MEM;
                end else begin
                    mRD = (exCls == CLS_LW);
                    mWR = (exCls == CLS_SW);
                    if (mem_ready) begin
                        if (exCls == CLS_SW) begin
                            PCWre     = 1'b1;
                            retire    = 1'b1;
                            nextState = S_IF;
                        end else begin
                            nextState = S_WB_LD;
                        end
                    end
                end
            end
            S_WB_LD: begin
                RegWre    = 1'b1;
                RegDst    = DST_RT;
                WrRegDSrc = 1'b1;
                DBDataSrc = 1'b1;
                PCWre     = 1'b1;
                retire    = 1'b1;
                nextState = S_IF;
            end
            S_HALT: nextState = S_HALT;
            default: nextState = S_IF;
        endcase
    end

endmodule
